// File: rtl/regbank_dump_ctrl_pkg.sv
// Shared debug-unit definitions for the register-bank dump sequencer.
// Optional checksum state is present only when REGBANK_DUMP_CHECKSUM_EN is defined.
package regbank_dump_ctrl_pkg;

  localparam int DEF_BANK_SIZE = 32;
  localparam int DEF_REG_SIZE  = 32;
  localparam int DEF_BYTE_SIZE = 8;
  localparam int BYTES_PER_REG = DEF_REG_SIZE / DEF_BYTE_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_DONE      = 3'd3
`ifdef REGBANK_DUMP_CHECKSUM_EN
    ,
    ST_SEND_CSUM = 3'd4
`endif
  } state_t;

  function automatic int bytes_per_reg(input int reg_size, input int byte_size);
    return reg_size / byte_size;
  endfunction

endpackage

// File: rtl/regbank_dump_shifter.sv
// Word holder for one register: parallel load, MSB-first byte shift, byte counter.
// Zero latency from load to first byte; shifts only when the consumer takes a byte.
module regbank_dump_shifter
  import regbank_dump_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_REG_SIZE,
  parameter int BYTE_W = DEF_BYTE_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              shift,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              last
);

  localparam int NBYTES = bytes_per_reg(WORD_W, BYTE_W);
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= word;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= sreg << BYTE_W;
      cnt  <= cnt + 1'b1;
    end
  end

  assign tx_byte = sreg[WORD_W-1 -: BYTE_W];
  assign last    = (cnt == CNT_W'(NBYTES - 1));

endmodule

// File: rtl/regbank_dump_ctrl.sv
// Dumps the register bank MSB-first onto a valid/ready byte stream; 1+bytes/reg cycles per register,
// output held while i_tx_ready is low. REGBANK_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module regbank_dump_ctrl
  import regbank_dump_ctrl_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = DEF_BANK_SIZE,
  parameter int REGISTERS_SIZE      = DEF_REG_SIZE,
  parameter int BYTE_SIZE           = DEF_BYTE_SIZE
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_start,
  output logic [$clog2(REGISTERS_BANK_SIZE)-1:0] o_rd_addr,
  input  logic [REGISTERS_SIZE-1:0]              i_rd_data,
  output logic [BYTE_SIZE-1:0]                   o_tx_data,
  output logic                                   o_tx_valid,
  input  logic                                   i_tx_ready,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int IDX_W = $clog2(REGISTERS_BANK_SIZE);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic                 load, shift;
  logic                 byte_last, last_reg;
  logic [BYTE_SIZE-1:0] sh_byte;

  regbank_dump_shifter #(
    .WORD_W (REGISTERS_SIZE),
    .BYTE_W (BYTE_SIZE)
  ) u_shifter (
    .clk     (i_clk),
    .reset   (i_reset),
    .load    (load),
    .word    (i_rd_data),
    .shift   (shift),
    .tx_byte (sh_byte),
    .last    (byte_last)
  );

  assign last_reg  = (idx == IDX_W'(REGISTERS_BANK_SIZE - 1));
  assign o_rd_addr = idx;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                                idx <= '0;
    else if (state == ST_IDLE && i_start)       idx <= '0;
    else if (shift && byte_last && !last_reg)   idx <= idx + 1'b1;
  end

`ifdef REGBANK_DUMP_CHECKSUM_EN
  logic [BYTE_SIZE-1:0] csum;

  // Only data bytes are folded in; the checksum byte itself is not.
  always_ff @(posedge i_clk) begin
    if (i_reset)                          csum <= '0;
    else if (state == ST_IDLE && i_start) csum <= '0;
    else if (shift)                       csum <= csum ^ sh_byte;
  end
`endif

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    shift      = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy    = 1'b1;
        load      = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = sh_byte;
        if (i_tx_ready) begin
          shift = 1'b1;
          if (byte_last) begin
`ifdef REGBANK_DUMP_CHECKSUM_EN
            state_nxt = last_reg ? ST_SEND_CSUM : ST_LOAD;
`else
            state_nxt = last_reg ? ST_DONE : ST_LOAD;
`endif
          end
        end
      end
`ifdef REGBANK_DUMP_CHECKSUM_EN
      ST_SEND_CSUM: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = csum;
        if (i_tx_ready) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Scoreboard bench: stimulus queues expected bytes/addresses, a negedge monitor pops and compares.
module tb_regbank_dump_ctrl;

`ifdef REGBANK_DUMP_CHECKSUM_EN
  localparam int NBYTES = 129;
  localparam int LAT    = 162;
`else
  localparam int NBYTES = 128;
  localparam int LAT    = 161;
`endif

  logic        clk;
  logic        i_reset, i_start, i_tx_ready;
  logic [4:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, o_busy, o_done;

  logic [31:0] bank [32];
  logic [7:0]  exp_q [$];
  int          addr_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_bytes  = 0;
  logic [7:0] last_byte;
  logic       stall_pend = 1'b0;
  logic [7:0] held;

  regbank_dump_ctrl dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  assign i_rd_data = bank[o_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_dump();
    logic [31:0] w;
    logic [7:0]  x;
    x = 8'h00;
    for (int k = 0; k < 32; k++) begin
      w = bank[k];
      addr_q.push_back(k);
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[31-8*b -: 8]);
        x = x ^ w[31-8*b -: 8];
      end
    end
`ifdef REGBANK_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Monitor: byte scoreboard, stall stability and LOAD-address checks.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (stall_pend) begin
        check("stall_valid", {31'd0, o_tx_valid}, 32'd1);
        check("stall_data", {24'd0, o_tx_data}, {24'd0, held});
      end
      stall_pend = o_tx_valid && !i_tx_ready;
      held       = o_tx_data;
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) check("byte_queue_nonempty", exp_q.size(), 1);
        else check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
        n_bytes++;
        last_byte = o_tx_data;
      end
      if (o_busy && !o_tx_valid) begin
        if (addr_q.size() == 0) check("addr_queue_nonempty", addr_q.size(), 1);
        else check("load_addr", {27'd0, o_rd_addr}, addr_q.pop_front());
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_addr"}, {27'd0, o_rd_addr}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, o_tx_data}, 32'd0);
    check({tag, "_tx_valid"}, {31'd0, o_tx_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, o_done}, 32'd0);
  endtask

  task automatic run_dump(input bit toggle, input bit restart, input bit timing);
    int t0, first_vld, done_cnt, done_cyc, busy_err, post;
    push_dump();
    n_bytes = 0; first_vld = -1; done_cnt = 0; done_cyc = 0; busy_err = 0; post = 0;
    i_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int it = 0; it < 3000 && post < 3; it++) begin
      if (o_tx_valid && first_vld < 0) first_vld = cyc;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", {31'd0, o_busy}, 32'd0);
      end else if (done_cnt == 0 && !o_busy) begin
        busy_err++;
      end
      if (done_cnt > 0) post++;
      if (toggle) i_tx_ready = ~i_tx_ready;
      i_start = (restart && it == 40);
      @(posedge clk); #1;
    end
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
    check("done_pulses", done_cnt, 1);
    check("byte_count", n_bytes, NBYTES);
    check("exp_queue_drained", exp_q.size(), 0);
    check("addr_queue_drained", addr_q.size(), 0);
    check("busy_gaps", busy_err, 0);
    if (timing) begin
      check("first_valid_latency", first_vld - t0, 2);
      check("done_latency", done_cyc - t0, LAT);
    end
  endtask

  task automatic reset_mid_dump();
    push_dump();
    n_bytes    = 0;
    i_tx_ready = 1'b1;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int it = 0; it < 200 && n_bytes < 10; it++) begin
      @(posedge clk); #1;
    end
    check("bytes_before_reset", n_bytes, 10);
    i_reset    = 1'b1;
    i_tx_ready = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("mid_reset");
    i_reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    i_tx_ready = 1'b1;
  endtask

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_tx_ready = 1'b0;
    for (int k = 0; k < 32; k++) bank[k] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    i_reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 32; k++) bank[k] = 32'h0101_0101 * k;
    i_tx_ready = 1'b1;
    run_dump(1'b0, 1'b0, 1'b1);

    run_dump(1'b1, 1'b0, 1'b0);

    bank[5] = 32'hDEAD_BEEF;
    run_dump(1'b0, 1'b1, 1'b0);

    reset_mid_dump();
    run_dump(1'b0, 1'b0, 1'b1);

`ifdef REGBANK_DUMP_CHECKSUM_EN
    for (int k = 0; k < 32; k++) bank[k] = 32'hFFFF_FFFF;
    run_dump(1'b0, 1'b0, 1'b0);
    check("csum_all_ones", {24'd0, last_byte}, 32'h00);
    for (int k = 0; k < 32; k++) bank[k] = 32'd0;
    bank[1] = 32'h0000_0001;
    run_dump(1'b0, 1'b0, 1'b0);
    check("csum_single_one", {24'd0, last_byte}, 32'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
